// File: rtl/score_counter.sv
// score_counter
//   Two-digit BCD score register fed by the pushbutton processor. Rising
//   edges on count_up_i / count_down_i step the score within 0..MAX_SCORE.
//   The BCD digits are counted directly rather than converted from binary.
//
//   Parameter:
//     MAX_SCORE     upper score bound, 1..99 (default 99)
//   Ports:
//     clk_1khz      system clock
//     rst_i         synchronous active-high reset
//     count_up_i    increment request (level or pulse, edge-detected)
//     count_down_i  decrement request (level or pulse, edge-detected)
//     score_o       binary score
//     ones_o        BCD ones digit
//     tens_o        BCD tens digit
//     changed_o     one-cycle pulse on every actual score change
//     at_max_o      high while score_o == MAX_SCORE
//     at_min_o      high while score_o == 0
//   Build option:
//     SCORE_WRAP_EN defined -> wrap-around at the limits (up at MAX -> 0,
//                   down at 0 -> MAX); undefined -> saturate at the limits.
module score_counter #(
  parameter int unsigned MAX_SCORE = 99
) (
  input  logic       clk_1khz,
  input  logic       rst_i,
  input  logic       count_up_i,
  input  logic       count_down_i,
  output logic [6:0] score_o,
  output logic [3:0] ones_o,
  output logic [3:0] tens_o,
  output logic       changed_o,
  output logic       at_max_o,
  output logic       at_min_o
);

  localparam logic [6:0] MAX7 = 7'(MAX_SCORE);
`ifdef SCORE_WRAP_EN
  localparam logic [3:0] MAX_TENS = 4'(MAX_SCORE / 10);
  localparam logic [3:0] MAX_ONES = 4'(MAX_SCORE % 10);
`endif

  logic       up_q, up_d;
  logic       dn_q, dn_d;
  logic [6:0] score_q, score_d;
  logic [3:0] ones_q, ones_d;
  logic [3:0] tens_q, tens_d;
  logic       changed_q, changed_d;
  logic       at_max_q, at_max_d;
  logic       at_min_q, at_min_d;
  logic       up_evt, dn_evt;

  always_comb begin
    up_evt    = count_up_i & ~up_q;
    dn_evt    = count_down_i & ~dn_q;
    up_d      = count_up_i;
    dn_d      = count_down_i;
    score_d   = score_q;
    ones_d    = ones_q;
    tens_d    = tens_q;
    changed_d = 1'b0;

    // Coincident up and down edges cancel out.
    if (up_evt && !dn_evt) begin
      if (score_q == MAX7) begin
`ifdef SCORE_WRAP_EN
        score_d   = '0;
        ones_d    = '0;
        tens_d    = '0;
        changed_d = 1'b1;
`endif
      end else begin
        score_d   = score_q + 7'd1;
        changed_d = 1'b1;
        if (ones_q == 4'd9) begin
          ones_d = '0;
          tens_d = tens_q + 4'd1;
        end else begin
          ones_d = ones_q + 4'd1;
        end
      end
    end else if (dn_evt && !up_evt) begin
      if (score_q == '0) begin
`ifdef SCORE_WRAP_EN
        score_d   = MAX7;
        ones_d    = MAX_ONES;
        tens_d    = MAX_TENS;
        changed_d = 1'b1;
`endif
      end else begin
        score_d   = score_q - 7'd1;
        changed_d = 1'b1;
        if (ones_q == '0) begin
          ones_d = 4'd9;
          tens_d = tens_q - 4'd1;
        end else begin
          ones_d = ones_q - 4'd1;
        end
      end
    end

    // Flags are derived from the next score so they register alongside it.
    at_max_d = (score_d == MAX7);
    at_min_d = (score_d == '0);
  end

  always_ff @(posedge clk_1khz) begin
    if (rst_i) begin
      // Edge history starts high so an input already asserted at release is ignored.
      up_q      <= 1'b1;
      dn_q      <= 1'b1;
      score_q   <= '0;
      ones_q    <= '0;
      tens_q    <= '0;
      changed_q <= 1'b0;
      at_max_q  <= 1'b0;
      at_min_q  <= 1'b1;
    end else begin
      up_q      <= up_d;
      dn_q      <= dn_d;
      score_q   <= score_d;
      ones_q    <= ones_d;
      tens_q    <= tens_d;
      changed_q <= changed_d;
      at_max_q  <= at_max_d;
      at_min_q  <= at_min_d;
    end
  end

  assign score_o   = score_q;
  assign ones_o    = ones_q;
  assign tens_o    = tens_q;
  assign changed_o = changed_q;
  assign at_max_o  = at_max_q;
  assign at_min_o  = at_min_q;

endmodule

// File: tb/tb_score_counter.sv
`timescale 1ns/1ps
module tb_score_counter;

  localparam int unsigned MAX = 99;

  logic       clk_1khz;
  logic       rst_i;
  logic       count_up_i;
  logic       count_down_i;
  logic [6:0] score_o;
  logic [3:0] ones_o;
  logic [3:0] tens_o;
  logic       changed_o;
  logic       at_max_o;
  logic       at_min_o;

  int unsigned n_tests;
  int unsigned n_fail;
  int unsigned model;

  score_counter #(.MAX_SCORE(MAX)) dut (
    .clk_1khz    (clk_1khz),
    .rst_i       (rst_i),
    .count_up_i  (count_up_i),
    .count_down_i(count_down_i),
    .score_o     (score_o),
    .ones_o      (ones_o),
    .tens_o      (tens_o),
    .changed_o   (changed_o),
    .at_max_o    (at_max_o),
    .at_min_o    (at_min_o)
  );

  initial clk_1khz = 1'b0;
  always #5 clk_1khz = ~clk_1khz;

  typedef struct {
    logic        up;
    logic        dn;
    logic        rst;
    int unsigned score;
    logic        ch;
  } vec_t;

  // Apply one cycle of inputs, then compare all outputs just after the edge.
  task automatic cyc(input logic up, input logic dn, input logic rst,
                     input int unsigned exp_score, input logic exp_ch,
                     input string name);
    logic [6:0] e_s;
    logic [3:0] e_o, e_t;
    logic       e_mx, e_mn;
    count_up_i   = up;
    count_down_i = dn;
    rst_i        = rst;
    @(posedge clk_1khz);
    #1;
    e_s  = 7'(exp_score);
    e_o  = 4'(exp_score % 10);
    e_t  = 4'(exp_score / 10);
    e_mx = (exp_score == MAX);
    e_mn = (exp_score == 0);
    n_tests++;
    if (score_o !== e_s || ones_o !== e_o || tens_o !== e_t ||
        changed_o !== exp_ch || at_max_o !== e_mx || at_min_o !== e_mn) begin
      n_fail++;
      $display("FAIL %s: got score=%0d tens=%0d ones=%0d ch=%b max=%b min=%b, want score=%0d tens=%0d ones=%0d ch=%b max=%b min=%b",
               name, score_o, tens_o, ones_o, changed_o, at_max_o, at_min_o,
               e_s, e_t, e_o, exp_ch, e_mx, e_mn);
    end
    model = exp_score;
  endtask

  task automatic up_pulse(input string name);
    int unsigned nxt;
    nxt = model + 1;
    cyc(1'b1, 1'b0, 1'b0, nxt, 1'b1, name);
    cyc(1'b0, 1'b0, 1'b0, nxt, 1'b0, {name, "_rel"});
  endtask

  task automatic dn_pulse(input string name);
    int unsigned nxt;
    nxt = model - 1;
    cyc(1'b0, 1'b1, 1'b0, nxt, 1'b1, name);
    cyc(1'b0, 1'b0, 1'b0, nxt, 1'b0, {name, "_rel"});
  endtask

  vec_t vecs[7];

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    model        = 0;
    rst_i        = 1'b1;
    count_up_i   = 1'b1;
    count_down_i = 1'b0;

    // Reset release with count_up_i held high, then drop and raise it.
    vecs[0] = '{up: 1'b1, dn: 1'b0, rst: 1'b1, score: 0, ch: 1'b0};
    vecs[1] = '{up: 1'b1, dn: 1'b0, rst: 1'b1, score: 0, ch: 1'b0};
    vecs[2] = '{up: 1'b1, dn: 1'b0, rst: 1'b0, score: 0, ch: 1'b0};
    vecs[3] = '{up: 1'b1, dn: 1'b0, rst: 1'b0, score: 0, ch: 1'b0};
    vecs[4] = '{up: 1'b0, dn: 1'b0, rst: 1'b0, score: 0, ch: 1'b0};
    vecs[5] = '{up: 1'b1, dn: 1'b0, rst: 1'b0, score: 1, ch: 1'b1};
    vecs[6] = '{up: 1'b0, dn: 1'b0, rst: 1'b0, score: 1, ch: 1'b0};
    for (int i = 0; i < 7; i++)
      cyc(vecs[i].up, vecs[i].dn, vecs[i].rst, vecs[i].score, vecs[i].ch,
          $sformatf("vec%0d", i));

    // Up to 12 (carry at 10), then down to 9 (borrow).
    for (int i = 0; i < 11; i++) up_pulse($sformatf("up_to_%0d", model + 1));
    for (int i = 0; i < 3; i++) dn_pulse($sformatf("dn_to_%0d", model - 1));

    // Down to 5, then simultaneous edges.
    for (int i = 0; i < 4; i++) dn_pulse($sformatf("dn_to_%0d", model - 1));
    cyc(1'b1, 1'b1, 1'b0, 5, 1'b0, "simul_edges");
    cyc(1'b0, 1'b0, 1'b0, 5, 1'b0, "simul_rel");

    // Alternating inputs on consecutive edges.
    cyc(1'b1, 1'b0, 1'b0, 6, 1'b1, "alt_up");
    cyc(1'b0, 1'b1, 1'b0, 5, 1'b1, "alt_dn");
    cyc(1'b0, 1'b0, 1'b0, 5, 1'b0, "alt_rel");

    // Held input counts once.
    cyc(1'b1, 1'b0, 1'b0, 6, 1'b1, "hold_first");
    cyc(1'b1, 1'b0, 1'b0, 6, 1'b0, "hold_second");
    cyc(1'b0, 1'b0, 1'b0, 6, 1'b0, "hold_rel");

    // Lower limit.
    for (int i = 0; i < 6; i++) dn_pulse($sformatf("dn_to_%0d", model - 1));
`ifdef SCORE_WRAP_EN
    cyc(1'b0, 1'b1, 1'b0, MAX, 1'b1, "dn_at_min_wrap");
    cyc(1'b0, 1'b0, 1'b0, MAX, 1'b0, "dn_at_min_wrap_rel");
    cyc(1'b0, 1'b0, 1'b1, 0, 1'b0, "reset_after_wrap");
    cyc(1'b0, 1'b0, 1'b0, 0, 1'b0, "reset_after_wrap_rel");
`else
    cyc(1'b0, 1'b1, 1'b0, 0, 1'b0, "dn_at_min_sat");
    cyc(1'b0, 1'b0, 1'b0, 0, 1'b0, "dn_at_min_sat_rel");
`endif

    // Upper limit.
    for (int i = 0; i < int'(MAX); i++) up_pulse($sformatf("up_to_%0d", model + 1));
`ifdef SCORE_WRAP_EN
    cyc(1'b1, 1'b0, 1'b0, 0, 1'b1, "up_at_max_wrap");
    cyc(1'b0, 1'b0, 1'b0, 0, 1'b0, "up_at_max_wrap_rel");
`else
    cyc(1'b1, 1'b0, 1'b0, MAX, 1'b0, "up_at_max_sat");
    cyc(1'b0, 1'b0, 1'b0, MAX, 1'b0, "up_at_max_sat_rel");
`endif

    // Mid-operation reset at 37 coinciding with an up edge.
    cyc(1'b0, 1'b0, 1'b1, 0, 1'b0, "reset_to_zero");
    cyc(1'b0, 1'b0, 1'b0, 0, 1'b0, "reset_rel");
    for (int i = 0; i < 37; i++) up_pulse($sformatf("up_to_%0d", model + 1));
    cyc(1'b1, 1'b0, 1'b1, 0, 1'b0, "reset_beats_up");
    cyc(1'b1, 1'b0, 1'b0, 0, 1'b0, "held_after_reset");
    cyc(1'b0, 1'b0, 1'b0, 0, 1'b0, "held_after_reset_rel");
    up_pulse("up_after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
